// File: rtl/regime_count_arbiter_pkg.sv
// Shared encodings for the regime count arbiter: requester port indices and
// run-counting modes.
package regime_count_arbiter_pkg;

  localparam int unsigned NumPorts = 2;

  typedef enum logic {
    Port0 = 1'b0,
    Port1 = 1'b1
  } port_e;

  typedef enum logic {
    LeadingOnes  = 1'b0,
    LeadingZeros = 1'b1
  } mode_e;

  function automatic port_e other_port(input port_e p);
    return (p == Port0) ? Port1 : Port0;
  endfunction

  // Leading-zeros mode is a leading-ones count on the inverted word.
  function automatic logic invert_for(input mode_e m);
    return (m == LeadingZeros);
  endfunction

endpackage

// File: rtl/regime_count_arbiter_clo.sv
// Count-leading-ones datapath: locates the highest 0 bit of the word and
// derives the run length from it.
module regime_count_arbiter_clo #(
  parameter int unsigned N = 8,
  parameter int unsigned S = $clog2(N)
) (
  input  logic [N-1:0] word,
  output logic [S-1:0] count,
  output logic [S-1:0] index,
  output logic         all
);

  localparam logic [S-1:0] TopIdx = S'(N - 1);

  always_comb begin
    index = '0;
    // Ascending scan, so the last hit is the highest 0 bit.
    for (int unsigned i = 0; i < N; i++) begin
      if (!word[i]) begin
        index = S'(i);
      end
    end
    all   = &word;
    count = TopIdx - index;
  end

endmodule

// File: rtl/regime_count_arbiter.sv
// Two-requester round-robin front end sharing one leading-run counter, with a
// one-entry registered response slot per requester.
module regime_count_arbiter
  import regime_count_arbiter_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_bits,
  input  logic         req0_mode,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [S-1:0] rsp0_count,
  output logic [S-1:0] rsp0_index,
  output logic         rsp0_all,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_bits,
  input  logic         req1_mode,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [S-1:0] rsp1_count,
  output logic [S-1:0] rsp1_index,
  output logic         rsp1_all
);

  logic [NumPorts-1:0] req_valid;
  logic [NumPorts-1:0] rsp_ready;
  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] grant;

  logic [NumPorts-1:0] rsp_valid_q, rsp_valid_d;
  logic [S-1:0]        rsp_count_q [NumPorts];
  logic [S-1:0]        rsp_index_q [NumPorts];
  logic [NumPorts-1:0] rsp_all_q;

  port_e ptr_q, ptr_d;
  port_e win;

  logic [N-1:0] sel_bits;
  logic         sel_mode;
  logic [N-1:0] eff_word;
  logic [S-1:0] clo_count;
  logic [S-1:0] clo_index;
  logic         clo_all;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A slot being drained this cycle can accept a new result on the same edge.
  assign eligible = req_valid & ~(rsp_valid_q & ~rsp_ready);

  always_comb begin
    grant = '0;
    win   = Port0;
    unique case (eligible)
      2'b01: begin
        win   = Port0;
        grant = 2'b01;
      end
      2'b10: begin
        win   = Port1;
        grant = 2'b10;
      end
      2'b11: begin
        win   = ptr_q;
        grant = (ptr_q == Port1) ? 2'b10 : 2'b01;
      end
      default: begin
        win   = Port0;
        grant = '0;
      end
    endcase
    // Nothing is accepted while reset is held.
    if (!rst_n) begin
      grant = '0;
    end
  end

  assign ptr_d = (grant != '0) ? other_port(win) : ptr_q;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_bits = (win == Port1) ? req1_bits : req0_bits;
    sel_mode = (win == Port1) ? req1_mode : req0_mode;
    eff_word = invert_for(mode_e'(sel_mode)) ? ~sel_bits : sel_bits;
  end

  regime_count_arbiter_clo #(
    .N(N),
    .S(S)
  ) u_clo (
    .word  (eff_word),
    .count (clo_count),
    .index (clo_index),
    .all   (clo_all)
  );

  always_comb begin
    for (int k = 0; k < NumPorts; k++) begin
      rsp_valid_d[k] = rsp_valid_q[k] & ~rsp_ready[k];
      if (grant[k]) begin
        rsp_valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= Port0;
      rsp_valid_q <= '0;
      rsp_all_q   <= '0;
      for (int k = 0; k < NumPorts; k++) begin
        rsp_count_q[k] <= '0;
        rsp_index_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      for (int k = 0; k < NumPorts; k++) begin
        if (grant[k]) begin
          rsp_count_q[k] <= clo_count;
          rsp_index_q[k] <= clo_index;
          rsp_all_q[k]   <= clo_all;
        end
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_count = rsp_count_q[0];
  assign rsp0_index = rsp_index_q[0];
  assign rsp0_all   = rsp_all_q[0];

  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_count = rsp_count_q[1];
  assign rsp1_index = rsp_index_q[1];
  assign rsp1_all   = rsp_all_q[1];

endmodule

// File: tb/tb_regime_count_arbiter.sv
// Directed and randomized self-checking bench for regime_count_arbiter (N=8).
module tb_regime_count_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned S = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_mode;
  logic [N-1:0] req0_bits;
  logic         rsp0_valid, rsp0_ready, rsp0_all;
  logic [S-1:0] rsp0_count, rsp0_index;
  logic         req1_valid, req1_ready, req1_mode;
  logic [N-1:0] req1_bits;
  logic         rsp1_valid, rsp1_ready, rsp1_all;
  logic [S-1:0] rsp1_count, rsp1_index;

  int passed = 0;
  int total  = 0;

  logic [6:0] q0 [$];
  logic [6:0] q1 [$];
  logic [6:0] exp_f;

  always #5 clk = ~clk;

  regime_count_arbiter #(
    .N(N),
    .S(S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_bits  (req0_bits),
    .req0_mode  (req0_mode),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_count (rsp0_count),
    .rsp0_index (rsp0_index),
    .rsp0_all   (rsp0_all),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_bits  (req1_bits),
    .req1_mode  (req1_mode),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_count (rsp1_count),
    .rsp1_index (rsp1_index),
    .rsp1_all   (rsp1_all)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk from the MSB counting ones; packs {count, index, all}.
  function automatic logic [6:0] ref_fields(input logic [N-1:0] bits, input logic mode);
    logic [N-1:0] eff;
    int           run;
    logic         stop;
    eff  = mode ? ~bits : bits;
    run  = 0;
    stop = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!stop && eff[i]) run++;
      else stop = 1'b1;
    end
    if (run == N) return {3'd7, 3'd0, 1'b1};
    return {3'(run), 3'(N - 1 - run), 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard step, evaluated with inputs settled, before the next edge.
  task automatic score();
    chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
    if (rsp0_valid && rsp0_ready) begin
      if (q0.size() == 0) chk("rsp0_extra", 32'd1, 32'd0);
      else begin
        exp_f = q0.pop_front();
        chk("rsp0_rand", {25'd0, rsp0_count, rsp0_index, rsp0_all}, {25'd0, exp_f});
      end
    end
    if (rsp1_valid && rsp1_ready) begin
      if (q1.size() == 0) chk("rsp1_extra", 32'd1, 32'd0);
      else begin
        exp_f = q1.pop_front();
        chk("rsp1_rand", {25'd0, rsp1_count, rsp1_index, rsp1_all}, {25'd0, exp_f});
      end
    end
    if (req0_valid && req0_ready) q0.push_back(ref_fields(req0_bits, req0_mode));
    if (req1_valid && req1_ready) q1.push_back(ref_fields(req1_bits, req1_mode));
  endtask

  initial begin
    // Reset with both requesters already asserting valid.
    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_bits = 8'hFF; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_bits = 8'hFF; req1_mode = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #2;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_fields", {rsp0_count, rsp0_index, rsp0_all}, 0);
    chk("rst_rsp1_fields", {rsp1_count, rsp1_index, rsp1_all}, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b0;
    rst_n      = 1'b1;
    tick();

    // Port 0 alone: 1100_1000 leading ones -> count 2, index 5.
    req0_valid = 1'b1; req0_bits = 8'b1100_1000; req0_mode = 1'b0;
    #1;
    chk("solo0_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    chk("solo0_valid", rsp0_valid, 1);
    chk("solo0_fields", {rsp0_count, rsp0_index, rsp0_all}, {3'd2, 3'd5, 1'b0});
    tick();
    chk("drain0_valid", rsp0_valid, 0);

    // Port 1 leading zeros, then all-zero word back-to-back into a draining slot.
    req1_valid = 1'b1; req1_bits = 8'b0000_0001; req1_mode = 1'b1;
    #1;
    chk("solo1_ready", {req1_ready, req0_ready}, 2'b10);
    tick();
    chk("lz1_fields", {rsp1_valid, rsp1_count, rsp1_index, rsp1_all}, {1'b1, 3'd7, 3'd0, 1'b0});
    req1_bits = 8'b0000_0000;
    #1;
    chk("reload1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("allz1_fields", {rsp1_valid, rsp1_count, rsp1_index, rsp1_all}, {1'b1, 3'd7, 3'd0, 1'b1});

    // Back-pressure on slot 0: port 1 must win while slot 0 holds.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_bits = 8'hF0; req0_mode = 1'b0;
    tick();
    chk("bp0_load", {rsp0_valid, rsp0_count, rsp0_index, rsp0_all}, {1'b1, 3'd4, 3'd3, 1'b0});
    req0_bits  = 8'h00;
    req1_valid = 1'b1; req1_bits = 8'hE0; req1_mode = 1'b0;
    #1;
    chk("bp_ready", {req1_ready, req0_ready}, 2'b10);
    tick();
    req1_valid = 1'b0;
    chk("bp0_hold", {rsp0_valid, rsp0_count, rsp0_index, rsp0_all}, {1'b1, 3'd4, 3'd3, 1'b0});
    chk("bp1_fields", {rsp1_valid, rsp1_count, rsp1_index, rsp1_all}, {1'b1, 3'd3, 3'd4, 1'b0});
    #1;
    chk("bp0_stall", req0_ready, 0);
    tick();
    chk("bp0_hold2", {rsp0_count, rsp0_index, rsp0_all}, {3'd4, 3'd3, 1'b0});
    rsp0_ready = 1'b1;
    #1;
    chk("bp0_release", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("msb0_fields", {rsp0_valid, rsp0_count, rsp0_index, rsp0_all}, {1'b1, 3'd0, 3'd7, 1'b0});

    // Reset lands while slot 0 is full and port 1 is being granted.
    rsp0_ready = 1'b0;
    req1_valid = 1'b1; req1_bits = 8'hC0; req1_mode = 1'b0;
    #1;
    chk("pre_rst_grant1", req1_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    chk("mid_rst_fields0", {rsp0_count, rsp0_index, rsp0_all}, 0);
    tick();
    req1_valid = 1'b0;
    rst_n      = 1'b1;
    rsp0_ready = 1'b1;
    tick();
    chk("post_rst_valid", {rsp1_valid, rsp0_valid}, 0);

    // Both requesting every cycle: grants alternate starting at port 0.
    req0_valid = 1'b1; req0_bits = 8'b1110_0000; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_bits = 8'b0000_1111; req1_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (i % 2 == 0) begin
        chk("rr_valid", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("rr_rsp0", {rsp0_count, rsp0_index, rsp0_all}, {3'd3, 3'd4, 1'b0});
      end else begin
        chk("rr_valid", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("rr_rsp1", {rsp1_count, rsp1_index, rsp1_all}, {3'd4, 3'd3, 1'b0});
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

    // Randomized traffic against the reference scoreboard.
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_bits  = 8'($urandom);
      req1_bits  = 8'($urandom);
      req0_mode  = 1'($urandom_range(0, 1));
      req1_mode  = 1'($urandom_range(0, 1));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      score();
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      score();
      tick();
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_valid", {rsp1_valid, rsp0_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regime_count_arbiter.md
REGIME_COUNT_ARBITER -- requirements
Module: regime_count_arbiter

Interface
REQ-001 Parameter N, default 8: width of the operand words presented by requesters.
REQ-002 Parameter S, default $clog2(N): width of count and index results.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqK_valid  input  1  (K=0,1) requester K presents an operand.
REQ-006 reqK_ready  output  1  (K=0,1) operand accepted this cycle when reqK_valid and reqK_ready are both high.
REQ-007 reqK_bits  input  N  (K=0,1) operand word, MSB first.
REQ-008 reqK_mode  input  1  (K=0,1) 0 = count leading ones, 1 = count leading zeros.
REQ-009 rspK_valid  output  1  (K=0,1) result for requester K is held.
REQ-010 rspK_ready  input  1  (K=0,1) requester K consumes the result when rspK_valid and rspK_ready are both high.
REQ-011 rspK_count  output  S  (K=0,1) leading-run length.
REQ-012 rspK_index  output  S  (K=0,1) bit index of the first bit that breaks the run.
REQ-013 rspK_all  output  1  (K=0,1) whole word is one run (no breaking bit).

Function
REQ-014 One shared leading-run counter datapath SHALL serve both requesters; at most one request is granted per cycle.
REQ-015 Effective word = reqK_bits when mode 0, bitwise inverse when mode 1; the count is taken on the effective word as a leading-ones count.
REQ-016 Port K is eligible when reqK_valid is high and its response slot is empty or is being consumed in the same cycle (rspK_valid and rspK_ready).
REQ-017 Only one eligible port -> that port is granted; both eligible -> the port selected by the round-robin pointer is granted.
REQ-018 The pointer SHALL update only on a grant, to the port not granted; it is unchanged in cycles with no grant.
REQ-019 reqK_ready SHALL be high exactly when port K is granted; it is combinational and SHALL NOT depend on reqK_valid of the other port beyond the arbitration rule.
REQ-020 The result SHALL be registered into slot K on the grant edge; rspK_valid rises the following cycle (latency 1).
REQ-021 rspK_index = highest bit position holding 0 in the effective word; rspK_count = (N-1) - rspK_index, computed modulo 2^S.
REQ-022 Effective word all ones -> rspK_all=1, rspK_count=N-1, rspK_index=0; otherwise rspK_all=0.
REQ-023 Effective word MSB 0 -> rspK_count=0, rspK_index=N-1.
REQ-024 Slot K holds its fields stable while rspK_valid is high and rspK_ready is low.
REQ-025 Consume and new grant to the same port in one cycle -> slot reloads with new result; rspK_valid stays high.
REQ-026 Consume with no new grant -> rspK_valid falls the next cycle.
REQ-027 Requests are accepted back-to-back, one per cycle, when the winning slot is drained each cycle.

Reset
REQ-028 rst_n low SHALL immediately force rspK_valid=0, rspK_count=0, rspK_index=0, rspK_all=0 for both ports and the pointer to port 0.
REQ-029 During reset reqK_ready SHALL be 0; a request in flight at reset assertion is dropped and not reported.
REQ-030 First grant after reset deassertion with both ports eligible SHALL go to port 0.

Structure
REQ-031 Port index encoding and the mode encoding (LEADING_ONES=0, LEADING_ZEROS=1) SHALL live in the shared ppu package.
REQ-032 The counting datapath SHALL be one instantiation of the existing count-leading-ones sub-module (clo), fed by a 2:1 operand mux; no second counter instance.

Verification
REQ-033 N=8, req0 bits=8'b1100_1000 mode 0 alone -> next cycle rsp0_valid=1, count=2, index=5, all=0.
REQ-034 req1 bits=8'b0000_0001 mode 1 -> count=7, index=0, all=0; bits=8'b0000_0000 mode 1 -> count=7, index=0, all=1.
REQ-035 Both ports valid every cycle, both rsp_ready=1, after reset -> grants 0,1,0,1...; each rsp valid on alternate cycles with correct results.
REQ-036 rsp0_ready=0 with slot 0 full, req0 and req1 valid -> req0_ready=0, port 1 granted, slot 0 fields unchanged until rsp0_ready=1.
REQ-037 rst_n pulsed low while rsp0_valid=1 and req1 granted that cycle -> all rsp_valid=0 immediately, no response appears after deassertion.
REQ-038 Random operands and modes on both ports with random rsp_ready -> every result matches a reference count, per-port order preserved, no loss or duplication.
